// File: rtl/unsigned_mul_8x8_ha_array_accum.sv
// ---------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_accum
//
// Final-reduction stage behind an 8x8 unsigned HA-array multiplier.
//
// The block captures four compressed partial-product rows in a single
// valid/ready handshake. It then adds them into an accumulator, one row per
// cycle. When all four rows are in, it presents the product on a valid/ready
// output.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_valid       a row set is present on ha_array_* inputs
//   in_ready       block accepts a row set this cycle
//   ha_array_k_t   row k top word, bit i has weight 2^(2k+i)      (k=0..3)
//   ha_array_k_b   row k bottom word, bit i has weight 2^(2k+i+2) (k=0..3)
//   out_valid      product valid; held until out_ready
//   out_ready      downstream accepts the product
//   product        sum of all rows (wrapped or clamped to P_W bits)
//   overflow       some row add exceeded P_W bits during this operation
//
// Parameters
//   P_W       product width (17 holds the largest possible row sum exactly)
//   SATURATE  1: clamp to all-ones on overflow, 0: wrap modulo 2^P_W
// ---------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_accum #(
    parameter int P_W      = 17,
    parameter bit SATURATE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8:0]     ha_array_0_t,
    input  logic [6:0]     ha_array_0_b,
    input  logic [8:0]     ha_array_1_t,
    input  logic [6:0]     ha_array_1_b,
    input  logic [8:0]     ha_array_2_t,
    input  logic [6:0]     ha_array_2_b,
    input  logic [8:0]     ha_array_3_t,
    input  logic [6:0]     ha_array_3_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product,
    output logic           overflow
);

    // A shifted row is at most 10 + 6 = 16 bits wide; 17 leaves headroom.
    localparam int RW = 17;
    // Adder width: wide enough for both the full row value and a carry
    // out of P_W bits, so truncation can never hide an overflow.
    localparam int SW = ((P_W > RW) ? P_W : RW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [P_W-1:0]      acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [3:0][8:0]     t_q, t_d;
    logic [3:0][6:0]     b_q, b_d;

    logic [3:0][8:0]     t_in;
    logic [3:0][6:0]     b_in;
    logic [3:0][RW-1:0]  row_val;
    logic [SW-1:0]       sum_w;
    logic                carry;
    logic                capture;

    assign t_in = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
    assign b_in = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};

    // Row k value: (t_k + 4*b_k) << 2k. The sum fits in 10 bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            logic [9:0] base;
            assign base        = {1'b0, t_q[gi]} + {1'b0, b_q[gi], 2'b00};
            assign row_val[gi] = {7'd0, base} << (2 * gi);
        end
    endgenerate

    assign sum_w = SW'(acc_q) + SW'(row_val[row_q]);
    assign carry = |sum_w[SW-1:P_W];

    // The accept path from DONE is combinational on out_ready. This lets
    // a new row set enter in the same cycle the old product leaves.
    // in_ready is held low while reset is asserted.
    assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign capture  = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        t_d     = t_q;
        b_d     = b_q;

        if (capture) begin
            t_d     = t_in;
            b_d     = b_in;
            acc_d   = '0;
            ovf_d   = 1'b0;
            row_d   = 2'd0;
            state_d = ACC;
        end else begin
            case (state_q)
                ACC: begin
                    if (carry && SATURATE) begin
                        acc_d = {P_W{1'b1}};
                    end else begin
                        acc_d = sum_w[P_W-1:0];
                    end
                    ovf_d = ovf_q | carry;
                    if (row_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            t_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            t_q     <= t_d;
            b_q     <= b_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign product   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_accum.sv
module tb_unsigned_mul_8x8_ha_array_accum;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [3:0][8:0] t_drv;
    logic [3:0][6:0] b_drv;

    logic            in_ready, out_valid, overflow;
    logic [16:0]     product;
    logic            in_ready_s, out_valid_s, overflow_s;
    logic [15:0]     product_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unsigned_mul_8x8_ha_array_accum #(.P_W(17), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ha_array_0_t(t_drv[0]), .ha_array_0_b(b_drv[0]),
        .ha_array_1_t(t_drv[1]), .ha_array_1_b(b_drv[1]),
        .ha_array_2_t(t_drv[2]), .ha_array_2_b(b_drv[2]),
        .ha_array_3_t(t_drv[3]), .ha_array_3_b(b_drv[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .overflow(overflow)
    );

    unsigned_mul_8x8_ha_array_accum #(.P_W(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ha_array_0_t(t_drv[0]), .ha_array_0_b(b_drv[0]),
        .ha_array_1_t(t_drv[1]), .ha_array_1_b(b_drv[1]),
        .ha_array_2_t(t_drv[2]), .ha_array_2_b(b_drv[2]),
        .ha_array_3_t(t_drv[3]), .ha_array_3_b(b_drv[3]),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .product(product_s), .overflow(overflow_s)
    );

    // Reference: sum over rows of (t + 4b) * 4^k, in plain integer arithmetic.
    function automatic longint ref_sum(input logic [3:0][8:0] t, input logic [3:0][6:0] b);
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            s += (longint'(t[k]) + 4 * longint'(b[k])) * (longint'(1) << (2 * k));
        end
        return s;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string           nm;
        logic [3:0][8:0] t;
        logic [3:0][6:0] b;
        longint          p;
        bit              o;
        longint          sp;
        bit              so;
    } vec_t;

    // One complete operation with out_ready held low until out_valid appears.
    task automatic run_op(input vec_t v);
        int w;
        int lat;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({v.nm, " in_ready"}, in_ready, 1);
        t_drv    = v.t;
        b_drv    = v.b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({v.nm, " latency"}, lat, 4);
        check({v.nm, " product"}, product, v.p);
        check({v.nm, " overflow"}, overflow, v.o);
        check({v.nm, " sat product"}, product_s, v.sp);
        check({v.nm, " sat overflow"}, overflow_s, v.so);
        $display("op %s: product=%0d ovf=%0d sat=%0d sat_ovf=%0d lat=%0d",
                 v.nm, product, overflow, product_s, overflow_s, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({v.nm, " out_valid drop"}, out_valid, 0);
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        int sent;
        int got;
        int cyc;
        longint q[$];
        longint e;
        vec_t v;

        vecs[0] = '{"zeros",  '0, '0, 0, 0, 0, 0};
        vecs[1] = '{"t0_1",   {9'd0, 9'd0, 9'd0, 9'd1}, '0, 1, 0, 1, 0};
        vecs[2] = '{"b3_1",   '0, {7'd1, 7'd0, 7'd0, 7'd0}, 256, 0, 256, 0};
        vecs[3] = '{"allmax", {4{9'h1FF}}, {4{7'h7F}}, 86615, 0, 65535, 1};
        vecs[4] = '{"t2_3",   {9'd0, 9'd3, 9'd0, 9'd0}, '0, 48, 0, 48, 0};
        vecs[5] = '{"b0_7f",  '0, {7'd0, 7'd0, 7'd0, 7'h7F}, 508, 0, 508, 0};
        vecs[6] = '{"t1_1ff", {9'd0, 9'd0, 9'h1FF, 9'd0}, '0, 2044, 0, 2044, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        t_drv = '0; b_drv = '0;
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset product", product, 0);
        check("reset overflow", overflow, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Stall with out_ready low: output held, new requests refused.
        @(negedge clk);
        t_drv = {9'd0, 9'd0, 9'd0, 9'd5}; b_drv = '0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; lat = 0;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("stall latency", lat, 4);
        in_valid = 1'b1; t_drv = {9'd0, 9'd0, 9'd1, 9'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall product", product, 5);
            check("stall out_valid", out_valid, 1);
            check("stall in_ready", in_ready, 0);
        end
        $display("stall: product=%0d held 10 cycles", product);
        out_ready = 1'b1;
        #1;
        check("handoff in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; lat = 0;
        check("handoff out_valid low", out_valid, 0);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        check("handoff latency", lat, 4);
        check("handoff product", product, 4);
        $display("handoff: product=%0d lat=%0d", product, lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of accumulation.
        @(negedge clk);
        t_drv = {4{9'h1FF}}; b_drv = {4{7'h7F}}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre-reset acc busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midreset product", product, 0);
        check("midreset out_valid", out_valid, 0);
        check("midreset in_ready", in_ready, 0);
        check("midreset overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset release in_ready", in_ready, 1);
        $display("midreset: outputs cleared");
        v = '{"after_reset", {9'd0, 9'd3, 9'd0, 9'd0}, '0, 48, 0, 48, 0};
        run_op(v);

        // Random traffic with random backpressure, scoreboard against model.
        sent = 0; got = 0; cyc = 0;
        while ((sent < 200 || q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                t_drv[k] = 9'($urandom);
                b_drv[k] = 7'($urandom);
            end
            out_ready = (sent >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                q.push_back(ref_sum(t_drv, b_drv));
                sent++;
            end
            if (out_valid && out_ready) begin
                check("rand result expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("rand product", product, e);
                    check("rand overflow", overflow, 0);
                    check("rand sat product", product_s, (e > 65535) ? 65535 : e);
                    check("rand sat overflow", overflow_s, (e > 65535) ? 1 : 0);
                    $display("rand %0d: product=%0d expected=%0d sat=%0d", got, product, e, product_s);
                end
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("rand sent", sent, 200);
        check("rand received", got, 200);
        check("rand outstanding", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
